// File: rtl/serial_subtractor_5_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state encoding.
package serial_subtractor_5_pkg;

  localparam int unsigned DEF_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_5_full_subtractor.sv
// 1-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor_5.sv
// Bit-serial A - B - Bin subtractor, LSB first, one bit per clock, start/busy/done handshake.
module serial_subtractor_5
  import serial_subtractor_5_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int unsigned     CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic             cell_d, cell_bout;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The unused encoding behaves exactly like IDLE, including accepting start.
  always_comb begin
    state_nxt = IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      SHIFT: begin
        busy      = 1'b1;
        state_nxt = last_bit ? DONE : SHIFT;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      default: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
    endcase
  end

  // D/Bout capture the completed word on the last shift so they are valid alongside done.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      Bout   <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      br   <= Bin;
      cnt  <= '0;
    end else if (busy) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      br     <= cell_bout;
      res_sr <= {cell_d, res_sr[WIDTH-1:1]};
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        D    <= {cell_d, res_sr[WIDTH-1:1]};
        Bout <= cell_bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_5.sv
// Directed and reference-model checks for the 5-bit bit-serial subtractor.
module tb_serial_subtractor_5;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] A, B;
  logic       Bin;
  logic       busy, done;
  logic [4:0] D;
  logic       Bout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic       bin;
    logic [4:0] d;
    logic       bout;
  } vec_t;

  vec_t vecs[8];

  serial_subtractor_5 #(.WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Present operands with start high; drop start just after the accepting edge.
  task automatic start_op(input logic [4:0] a, input logic [4:0] b, input logic bin);
    A     = a;
    B     = b;
    Bin   = bin;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count negedges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
  endtask

  initial begin
    int n;
    int seen;
    logic [4:0] ra, rb;
    logic       rbin;
    logic [5:0] ref_r;

    vecs[0] = '{a: 5'd13, b: 5'd6,  bin: 1'b0, d: 5'd7,  bout: 1'b0};
    vecs[1] = '{a: 5'd6,  b: 5'd13, bin: 1'b0, d: 5'd25, bout: 1'b1};
    vecs[2] = '{a: 5'd0,  b: 5'd0,  bin: 1'b1, d: 5'd31, bout: 1'b1};
    vecs[3] = '{a: 5'd31, b: 5'd31, bin: 1'b0, d: 5'd0,  bout: 1'b0};
    vecs[4] = '{a: 5'd31, b: 5'd0,  bin: 1'b1, d: 5'd30, bout: 1'b0};
    vecs[5] = '{a: 5'd0,  b: 5'd31, bin: 1'b0, d: 5'd1,  bout: 1'b1};
    vecs[6] = '{a: 5'd5,  b: 5'd5,  bin: 1'b1, d: 5'd31, bout: 1'b1};
    vecs[7] = '{a: 5'd16, b: 5'd15, bin: 1'b1, d: 5'd0,  bout: 1'b0};

    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    Bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_D",    int'(D),    0);
    chk("reset_Bout", int'(Bout), 0);
    reset = 1'b0;
    @(negedge clk);

    // First op: busy for exactly 5 samples, then done.
    start_op(5'd13, 5'd6, 1'b0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy && !done) seen++;
    end
    chk("busy_5_cycles", seen, 5);
    @(negedge clk);
    chk("first_done", int'(done), 1);
    chk("first_D", int'(D), 7);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done(n);
      chk("vec_latency", n, 6);
      chk("vec_D",    int'(D),    int'(vecs[i].d));
      chk("vec_Bout", int'(Bout), int'(vecs[i].bout));
      @(negedge clk);
      chk("vec_done_pulse", int'(done), 0);
    end

    // start and operand changes while busy are ignored.
    start_op(5'd9, 5'd3, 1'b1);
    @(negedge clk);
    A = 5'd1; B = 5'd30; Bin = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_latency", n, 6);
    chk("ignore_D",    int'(D),    5);
    chk("ignore_Bout", int'(Bout), 0);
    @(negedge clk);

    // Reset during SHIFT aborts; no done follows.
    start_op(5'd7, 5'd2, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_D",    int'(D),    0);
    chk("abort_Bout", int'(Bout), 0);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    start_op(5'd20, 5'd4, 1'b0);
    wait_done(n);
    chk("after_abort_latency", n, 6);
    chk("after_abort_D",    int'(D),    16);
    chk("after_abort_Bout", int'(Bout), 0);
    @(negedge clk);

    // Back-to-back: start held high so the second op is taken in the DONE cycle.
    A = 5'd10; B = 5'd3; Bin = 1'b0; start = 1'b1;
    wait_done(n);
    chk("b2b_first_latency", n, 6);
    chk("b2b_first_D",    int'(D),    7);
    chk("b2b_first_Bout", int'(Bout), 0);
    A = 5'd3; B = 5'd10; Bin = 1'b0;
    @(negedge clk);
    chk("b2b_no_double_done", int'(done), 0);
    chk("b2b_second_busy", int'(busy), 1);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_spacing", n, 6);
    chk("b2b_second_D",    int'(D),    25);
    chk("b2b_second_Bout", int'(Bout), 1);
    @(negedge clk);

    for (int k = 0; k < 1000; k++) begin
      ra    = 5'($urandom_range(0, 31));
      rb    = 5'($urandom_range(0, 31));
      rbin  = 1'($urandom_range(0, 1));
      ref_r = {1'b0, ra} - {1'b0, rb} - {5'b0, rbin};
      start_op(ra, rb, rbin);
      wait_done(n);
      chk("rand_latency", n, 6);
      chk("rand_D",    int'(D),    int'(ref_r[4:0]));
      chk("rand_Bout", int'(Bout), int'(ref_r[5]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
